// File: rtl/reset_sequencer_if.sv
// Reset sequencer bus.
// Groups the reset request inputs and the staged reset outputs of
// reset_sequencer.
//   btn_rst     : raw pushbutton reset request, active-high, asynchronous to clk
//   soft_rst    : synchronous reset request, active-high, level
//   reset_n_out : per-stage reset outputs, active-low
//   all_ready   : 1 when every reset_n_out bit is 1
//   seq_state   : 00 ASSERT, 01 RELEASE, 10 DONE
// The master modport is the side that raises the requests and watches the
// outputs. The slave modport is the sequencer itself.
interface reset_sequencer_if #(
  parameter int NUM_OUT = 3
);
  logic               btn_rst;
  logic               soft_rst;
  logic [NUM_OUT-1:0] reset_n_out;
  logic               all_ready;
  logic [1:0]         seq_state;

  modport master (
    output btn_rst,
    output soft_rst,
    input  reset_n_out,
    input  all_ready,
    input  seq_state
  );

  modport slave (
    input  btn_rst,
    input  soft_rst,
    output reset_n_out,
    output all_ready,
    output seq_state
  );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: power-on / system reset generator.
// After power-up, or after a reset request, all NUM_OUT active-low reset
// outputs are held low for HOLD cycles. They are then released one at a time
// in index order (0 first), STAGE_GAP cycles apart. Reset requests come from
// a synchronised, debounced pushbutton or from a synchronous soft reset.
// Ports:
//   clk : system clock
//   rst : asynchronous, active-high reset; clears all state
//   bus : reset_sequencer_if.slave
//         (btn_rst, soft_rst in; reset_n_out, all_ready, seq_state out)
module reset_sequencer #(
  parameter bit SIMULATION  = 1'b0,
  parameter int NUM_OUT     = 3,
  parameter int CNT_W       = 16,
  parameter int HOLD_CYCLES = 10000,
  parameter int STAGE_GAP   = 1000,
  parameter int DEBOUNCE    = 5000
) (
  input  logic              clk,
  input  logic              rst,
  reset_sequencer_if.slave  bus
);
  localparam int     HOLD    = SIMULATION ? 10 : HOLD_CYCLES;
  localparam int     GAP     = SIMULATION ? 2  : STAGE_GAP;
  localparam int     DB      = SIMULATION ? 4  : DEBOUNCE;
  localparam int     IDX_W   = $clog2(NUM_OUT + 1);
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  if (NUM_OUT < 1 || HOLD < 1 || GAP < 1 || DB < 1) begin : g_bad_range
    $error("reset_sequencer: NUM_OUT and all timing values must be >= 1");
  end
  if (longint'(HOLD - 1) > CNT_MAX || longint'(GAP - 1) > CNT_MAX ||
      longint'(DB) > CNT_MAX) begin : g_bad_width
    $error("reset_sequencer: timing values do not fit in CNT_W-bit counters");
  end

  typedef enum logic [1:0] {
    S_ASSERT  = 2'b00,
    S_RELEASE = 2'b01,
    S_DONE    = 2'b10
  } state_t;

  logic             sync1_q, btn_s_q, btn_db_q;
  logic [CNT_W-1:0] db_cnt_q;
  logic             req;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_OUT-1:0] rn_q, rn_d;
  logic               rdy_q, rdy_d;

  // Button synchroniser and debouncer. The debounced state flips only after
  // DB consecutive synced samples disagree with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      btn_s_q  <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync1_q <= bus.btn_rst;
      btn_s_q <= sync1_q;
      if (btn_s_q != btn_db_q) begin
        if (db_cnt_q == CNT_W'(DB - 1)) begin
          btn_db_q <= btn_s_q;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + CNT_W'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  assign req = btn_db_q | bus.soft_rst;

  // Sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rn_q    <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rn_q    <= rn_d;
      rdy_q   <= rdy_d;
    end
  end

  // Next state. A request wins over any release that falls due on the same
  // edge, so released bits only ever drop back as a whole group.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rn_d    = rn_q;
    rdy_d   = rdy_q;
    unique case (state_q)
      S_ASSERT: begin
        rn_d  = '0;
        rdy_d = 1'b0;
        idx_d = '0;
        if (req) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(HOLD - 1)) begin
          rn_d[0] = 1'b1;
          cnt_d   = '0;
          idx_d   = IDX_W'(1);
          if (NUM_OUT == 1) begin
            rdy_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        if (req) begin
          state_d = S_ASSERT;
          rn_d    = '0;
          rdy_d   = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == CNT_W'(GAP - 1)) begin
          rn_d  = rn_q | (NUM_OUT'(1) << idx_q);
          cnt_d = '0;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_OUT - 1)) begin
            rdy_d   = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (req) begin
          state_d = S_ASSERT;
          rn_d    = '0;
          rdy_d   = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = S_ASSERT;
        rn_d    = '0;
        rdy_d   = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  assign bus.reset_n_out = rn_q;
  assign bus.all_ready   = rdy_q;
  assign bus.seq_state   = state_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer. It runs a 3-output instance and a 1-output
// instance with SIMULATION=1 (HOLD=10, GAP=2, DB=4). The stimulus pushes the
// expected outputs into a queue, tagged with the cycle at which they must
// hold. A monitor samples on the falling edge and pops/compares any entry
// whose cycle has been reached.
module tb_reset_sequencer;
  localparam logic [1:0] A = 2'b00, R = 2'b01, D = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;

  typedef struct {
    int         cyc;
    int         which;
    logic [2:0] out;
    logic       rdy;
    logic [1:0] st;
    string      tag;
  } exp_t;

  exp_t sbq[$];

  reset_sequencer_if #(.NUM_OUT(3)) if3 ();
  reset_sequencer_if #(.NUM_OUT(1)) if1 ();

  reset_sequencer #(.SIMULATION(1'b1), .NUM_OUT(3)) dut3 (
    .clk(clk), .rst(rst), .bus(if3.slave));
  reset_sequencer #(.SIMULATION(1'b1), .NUM_OUT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic exp_at(input int c, input int w, input logic [2:0] o,
                        input logic r, input logic [1:0] s, input string t);
    exp_t e;
    e.cyc = c; e.which = w; e.out = o; e.rdy = r; e.st = s; e.tag = t;
    sbq.push_back(e);
  endtask

  // Leaves the caller 2 time units after the rising edge that makes cyc == n.
  task automatic goto(input int n);
    while (cyc != n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Returns the base cycle: edge k after release makes cyc == base + k.
  task automatic rst_pulse(output int base);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    base = cyc;
  endtask

  // Monitor: compares every queued expectation that has come due.
  always @(negedge clk) begin : mon
    exp_t       e;
    logic [2:0] ao;
    logic       ar;
    logic [1:0] as;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      n_total++;
      if (e.which == 0) begin
        ao = if3.reset_n_out; ar = if3.all_ready; as = if3.seq_state;
      end else begin
        ao = {2'b00, if1.reset_n_out}; ar = if1.all_ready; as = if1.seq_state;
      end
      if (e.cyc < cyc) begin
        n_bad++;
        $display("FAIL %s dut%0d: checked late at cycle %0d, required cycle %0d",
                 e.tag, e.which, cyc, e.cyc);
      end else if (ao !== e.out || ar !== e.rdy || as !== e.st) begin
        n_bad++;
        $display("FAIL %s dut%0d: got out=%b rdy=%b st=%b, want out=%b rdy=%b st=%b",
                 e.tag, e.which, ao, ar, as, e.out, e.rdy, e.st);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int b;
    if3.btn_rst = 1'b0; if3.soft_rst = 1'b0;
    if1.btn_rst = 1'b0; if1.soft_rst = 1'b0;
    @(posedge clk);
    #2;

    // 1: plain power-up release
    rst_pulse(b);
    exp_at(b,      0, 3'b000, 1'b0, A, "t1_reset");
    exp_at(b,      1, 3'b000, 1'b0, A, "t1_reset");
    exp_at(b + 9,  0, 3'b000, 1'b0, A, "t1_e9");
    exp_at(b + 9,  1, 3'b000, 1'b0, A, "t6_e9");
    exp_at(b + 10, 0, 3'b001, 1'b0, R, "t1_e10");
    exp_at(b + 10, 1, 3'b001, 1'b1, D, "t6_e10");
    exp_at(b + 11, 0, 3'b001, 1'b0, R, "t1_e11");
    exp_at(b + 12, 0, 3'b011, 1'b0, R, "t1_e12");
    exp_at(b + 13, 0, 3'b011, 1'b0, R, "t1_e13");
    exp_at(b + 14, 0, 3'b111, 1'b1, D, "t1_e14");
    goto(b + 15);

    // 2: asynchronous reset in the middle of RELEASE
    rst_pulse(b);
    exp_at(b + 11, 0, 3'b001, 1'b0, R, "t2_pre");
    goto(b + 12);
    rst = 1'b1;
    exp_at(b + 12, 0, 3'b000, 1'b0, A, "t2_async");
    exp_at(b + 12, 1, 3'b000, 1'b0, A, "t2_async");

    // 3: button glitch ignored, long press restarts the sequence
    rst_pulse(b);
    exp_at(b + 14, 0, 3'b111, 1'b1, D, "t3_done");
    goto(b + 16);
    if3.btn_rst = 1'b1;
    goto(b + 19);
    if3.btn_rst = 1'b0;
    exp_at(b + 24, 0, 3'b111, 1'b1, D, "t3_glitch");
    goto(b + 26);
    if3.btn_rst = 1'b1;
    exp_at(b + 32, 0, 3'b111, 1'b1, D, "t3_db_rise");
    exp_at(b + 33, 0, 3'b000, 1'b0, A, "t3_btn_assert");
    goto(b + 34);
    if3.btn_rst = 1'b0;
    exp_at(b + 49, 0, 3'b000, 1'b0, A, "t3_rel_e9");
    exp_at(b + 50, 0, 3'b001, 1'b0, R, "t3_rel_e10");
    exp_at(b + 53, 0, 3'b011, 1'b0, R, "t3_rel_e13");
    exp_at(b + 54, 0, 3'b111, 1'b1, D, "t3_rel_e14");
    goto(b + 55);

    // 4: one-cycle soft reset beats the stage-1 release due on the same edge
    rst_pulse(b);
    exp_at(b + 10, 0, 3'b001, 1'b0, R, "t4_e10");
    exp_at(b + 11, 0, 3'b001, 1'b0, R, "t4_e11");
    exp_at(b + 12, 0, 3'b000, 1'b0, A, "t4_soft");
    goto(b + 11);
    if3.soft_rst = 1'b1;
    goto(b + 12);
    if3.soft_rst = 1'b0;
    exp_at(b + 21, 0, 3'b000, 1'b0, A, "t4_re_e9");
    exp_at(b + 22, 0, 3'b001, 1'b0, R, "t4_re_e10");
    goto(b + 23);

    // 5: soft reset held for 20 cycles keeps everything in ASSERT
    rst_pulse(b);
    if3.soft_rst = 1'b1;
    exp_at(b + 5,  0, 3'b000, 1'b0, A, "t5_hold5");
    exp_at(b + 10, 0, 3'b000, 1'b0, A, "t5_hold10");
    exp_at(b + 10, 1, 3'b001, 1'b1, D, "t6_indep");
    exp_at(b + 15, 0, 3'b000, 1'b0, A, "t5_hold15");
    exp_at(b + 20, 0, 3'b000, 1'b0, A, "t5_hold20");
    goto(b + 20);
    if3.soft_rst = 1'b0;
    exp_at(b + 29, 0, 3'b000, 1'b0, A, "t5_e9");
    exp_at(b + 30, 0, 3'b001, 1'b0, R, "t5_e10");
    exp_at(b + 32, 0, 3'b011, 1'b0, R, "t5_e12");
    exp_at(b + 34, 0, 3'b111, 1'b1, D, "t5_e14");
    goto(b + 35);

    for (int i = 0; i < 100 && sbq.size() > 0; i++) @(negedge clk);
    #1;
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      n_total++;
      n_bad++;
      $display("FAIL %s dut%0d: never checked, required at cycle %0d",
               e.tag, e.which, e.cyc);
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
